// File: rtl/fifo_dual.sv
// Dual-lane push/pop FIFO with all-or-nothing push and clamped pop.
// Optional sticky error flag enabled by FIFO_DUAL_ERR_EN.
module fifo_dual #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           wNum,
  input  logic [WIDTH-1:0]     wData0,
  input  logic [WIDTH-1:0]     wData1,
  input  logic [1:0]           pop,
  output logic [WIDTH-1:0]     rData0,
  output logic [WIDTH-1:0]     rData1,
  output logic [PTR_WIDTH:0]   count,
  output logic                 isFull,
  output logic                 isEmpty,
  output logic                 almostFull,
  output logic                 wReady1,
  output logic                 wReady2
`ifdef FIFO_DUAL_ERR_EN
  ,
  output logic                 errFlag
`endif
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [WIDTH-1:0]     ram [DEPTH];
  logic [CW-1:0]        wStat;
  logic [CW-1:0]        rStat;
  logic [CW-1:0]        freeSlots;
  logic [CW-1:0]        wReq;
  logic [CW-1:0]        popReq;
  logic [CW-1:0]        wAdv;
  logic [CW-1:0]        popNum;
  logic [PTR_WIDTH-1:0] wPtr;
  logic [PTR_WIDTH-1:0] wPtr1;
  logic [PTR_WIDTH-1:0] rPtr;
  logic [PTR_WIDTH-1:0] rPtr1;
  logic                 pushOk;

  // Acceptance uses occupancy before any same-cycle pop.
  always_comb begin
    count     = wStat - rStat;
    freeSlots = DEPTH_C - count;
    wReq      = (wNum == 2'd3) ? '0 : CW'(wNum);
    popReq    = (pop == 2'd3) ? '0 : CW'(pop);
    pushOk    = wReq <= freeSlots;
    wAdv      = pushOk ? wReq : '0;
    popNum    = (popReq > count) ? count : popReq;
  end

  assign isEmpty    = count == '0;
  assign isFull     = count == DEPTH_C;
  assign almostFull = count >= AFULL_C;
  assign wReady1    = freeSlots >= CW'(1);
  assign wReady2    = freeSlots >= CW'(2);

  assign wPtr  = wStat[PTR_WIDTH-1:0];
  assign rPtr  = rStat[PTR_WIDTH-1:0];
  assign wPtr1 = wPtr + PTR_WIDTH'(1);
  assign rPtr1 = rPtr + PTR_WIDTH'(1);

  assign rData0 = ram[rPtr];
  assign rData1 = ram[rPtr1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wStat <= '0;
      rStat <= '0;
    end else if (flush) begin
      wStat <= '0;
      rStat <= '0;
    end else begin
      wStat <= wStat + wAdv;
      rStat <= rStat + popNum;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wAdv >= CW'(1)) ram[wPtr]  <= wData0;
      if (wAdv == CW'(2)) ram[wPtr1] <= wData1;
    end
  end

`ifdef FIFO_DUAL_ERR_EN
  logic errNow;

  assign errNow = (wNum == 2'd3) || (pop == 2'd3) ||
                  ((wReq != '0) && !pushOk) ||
                  (popReq > count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        errFlag <= 1'b0;
    else if (flush)  errFlag <= 1'b0;
    else if (errNow) errFlag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_dual.sv
// Bench for fifo_dual: vector table, corner sequences, random vs queue model.
// Checks errFlag too when FIFO_DUAL_ERR_EN is defined.
module tb_fifo_dual;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  wNum;
  logic [31:0] wData0;
  logic [31:0] wData1;
  logic [1:0]  pop;
  logic [31:0] rData0;
  logic [31:0] rData1;
  logic [3:0]  count;
  logic        isFull;
  logic        isEmpty;
  logic        almostFull;
  logic        wReady1;
  logic        wReady2;
`ifdef FIFO_DUAL_ERR_EN
  logic        errFlag;
`endif

  int compared = 0;
  int mismatched = 0;

  fifo_dual dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wNum(wNum), .wData0(wData0), .wData1(wData1),
    .pop(pop), .rData0(rData0), .rData1(rData1),
    .count(count), .isFull(isFull), .isEmpty(isEmpty),
    .almostFull(almostFull), .wReady1(wReady1), .wReady2(wReady2)
`ifdef FIFO_DUAL_ERR_EN
    , .errFlag(errFlag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [1:0]  wn;
    logic [1:0]  pp;
    logic [31:0] d0;
    logic [31:0] d1;
    int          eCnt;
    logic [31:0] eR0;
    logic [31:0] eR1;
  } vec_t;

  vec_t tbl[7];
  logic [31:0] q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(logic fl, logic [1:0] wn, logic [1:0] pp,
                      logic [31:0] d0, logic [31:0] d1);
    flush = fl; wNum = wn; pop = pp; wData0 = d0; wData1 = d1;
    @(posedge clk);
    #1;
    flush = 1'b0; wNum = 2'd0; pop = 2'd0;
  endtask

  task automatic doReset();
    rst = 1'b0; flush = 1'b0; wNum = 2'd0; pop = 2'd0;
    wData0 = '0; wData1 = '0;
    #3;
    chk("rst count", 32'(count), 32'd0);
    chk("rst isEmpty", 32'(isEmpty), 32'd1);
    chk("rst isFull", 32'(isFull), 32'd0);
    chk("rst almostFull", 32'(almostFull), 32'd0);
    chk("rst wReady1", 32'(wReady1), 32'd1);
    chk("rst wReady2", 32'(wReady2), 32'd1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, c, d, e;
    a = 32'hA0A0_0001; b = 32'hB0B0_0002; c = 32'hC0C0_0003;
    d = 32'hD0D0_0004; e = 32'hE0E0_0005;
    tbl[0] = '{1'b0, 2'd2, 2'd0, a, b, 2, a, b};
    tbl[1] = '{1'b0, 2'd2, 2'd0, c, d, 4, a, b};
    tbl[2] = '{1'b0, 2'd0, 2'd2, 0, 0, 2, c, d};
    tbl[3] = '{1'b0, 2'd3, 2'd0, e, e, 2, c, d};
    tbl[4] = '{1'b0, 2'd0, 2'd3, 0, 0, 2, c, d};
    tbl[5] = '{1'b0, 2'd1, 2'd2, e, 0, 1, e, 0};
    tbl[6] = '{1'b0, 2'd0, 2'd2, 0, 0, 0, 0, 0};

    doReset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].fl, tbl[i].wn, tbl[i].pp, tbl[i].d0, tbl[i].d1);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].eCnt));
      if (tbl[i].eCnt >= 1)
        chk($sformatf("vec%0d rData0", i), rData0, tbl[i].eR0);
      if (tbl[i].eCnt >= 2)
        chk($sformatf("vec%0d rData1", i), rData1, tbl[i].eR1);
    end

    // Full FIFO: same-cycle pop does not make room for a push.
    doReset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'd2, 2'd0, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i));
    chk("full isFull", 32'(isFull), 32'd1);
    chk("full wReady1", 32'(wReady1), 32'd0);
    step(1'b0, 2'd1, 2'd1, 32'hDEAD, 0);
    chk("fullpp count", 32'(count), 32'd7);
    chk("fullpp rData0", rData0, 32'h101);
    chk("fullpp rData1", rData1, 32'h102);
`ifdef FIFO_DUAL_ERR_EN
    chk("fullpp errFlag", 32'(errFlag), 32'd1);
`endif
    step(1'b0, 2'd2, 2'd0, 32'hBAD0, 32'hBAD1);
    chk("c7 count", 32'(count), 32'd7);
    chk("c7 wReady1", 32'(wReady1), 32'd1);
    chk("c7 wReady2", 32'(wReady2), 32'd0);
    chk("c7 rData0", rData0, 32'h101);

    // Read window straddling index 7 -> 0.
    doReset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'd2, 2'd0, 32'h200 + 32'(2*i), 32'h201 + 32'(2*i));
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 2'd2, 0, 0);
    step(1'b0, 2'd0, 2'd1, 0, 0);
    step(1'b0, 2'd1, 2'd0, 32'h300, 0);
    chk("wrap count", 32'(count), 32'd2);
    chk("wrap rData0", rData0, 32'h207);
    chk("wrap rData1", rData1, 32'h300);
    step(1'b0, 2'd0, 2'd2, 0, 0);
    chk("wrap isEmpty", 32'(isEmpty), 32'd1);
    step(1'b0, 2'd2, 2'd0, 32'h400, 32'h401);
    chk("wrap2 rData0", rData0, 32'h400);
    chk("wrap2 rData1", rData1, 32'h401);

    // Flush beats push and pop, clears the error flag.
    doReset();
    step(1'b0, 2'd2, 2'd0, 1, 2);
    step(1'b0, 2'd2, 2'd0, 3, 4);
    step(1'b0, 2'd1, 2'd3, 5, 0);
    chk("pre-flush count", 32'(count), 32'd5);
`ifdef FIFO_DUAL_ERR_EN
    chk("pre-flush errFlag", 32'(errFlag), 32'd1);
`endif
    step(1'b1, 2'd2, 2'd1, 6, 7);
    chk("flush count", 32'(count), 32'd0);
    chk("flush isEmpty", 32'(isEmpty), 32'd1);
`ifdef FIFO_DUAL_ERR_EN
    chk("flush errFlag", 32'(errFlag), 32'd0);
`endif

    // Asynchronous reset mid-cycle.
    doReset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd2, 2'd0, 9, 9);
    chk("af count", 32'(count), 32'd6);
    chk("af almostFull", 32'(almostFull), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async isEmpty", 32'(isEmpty), 32'd1);
    chk("async almostFull", 32'(almostFull), 32'd0);
    chk("async wReady2", 32'(wReady2), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against a queue model.
    doReset();
    q.delete();
    begin
      logic errM;
      errM = 1'b0;
      for (int n = 0; n < 800; n++) begin
        logic        fl;
        logic [1:0]  wn, pp;
        logic [31:0] d0, d1;
        int          nw, np, free, sz;
        fl = ($urandom_range(0, 40) == 0);
        wn = 2'($urandom_range(0, 3));
        pp = 2'($urandom_range(0, 3));
        d0 = $urandom; d1 = $urandom;
        nw = (wn == 2'd3) ? 0 : int'(wn);
        np = (pp == 2'd3) ? 0 : int'(pp);
        sz = q.size();
        free = 8 - sz;
        if (fl) begin
          q.delete();
          errM = 1'b0;
        end else begin
          if (wn == 2'd3 || pp == 2'd3 || (nw > free) || (np > sz))
            errM = 1'b1;
          for (int k = 0; k < np && q.size() > 0; k++) void'(q.pop_front());
          if (nw <= free) begin
            if (nw >= 1) q.push_back(d0);
            if (nw == 2) q.push_back(d1);
          end
        end
        step(fl, wn, pp, d0, d1);
        sz = q.size();
        chk("rnd count", 32'(count), 32'(sz));
        chk("rnd isFull", 32'(isFull), 32'(sz == 8));
        chk("rnd isEmpty", 32'(isEmpty), 32'(sz == 0));
        chk("rnd almostFull", 32'(almostFull), 32'(sz >= 6));
        chk("rnd wReady1", 32'(wReady1), 32'(sz <= 7));
        chk("rnd wReady2", 32'(wReady2), 32'(sz <= 6));
        if (sz >= 1) chk("rnd rData0", rData0, q[0]);
        if (sz >= 2) chk("rnd rData1", rData1, q[1]);
`ifdef FIFO_DUAL_ERR_EN
        chk("rnd errFlag", 32'(errFlag), 32'(errM));
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
